// File: rtl/ppc_mmu_pkg.sv
// Shared MMU definitions: exception codes, permission bit positions,
// access types and the search-engine state encoding.
package ppc_mmu_pkg;

  localparam int PAGE_SHIFT = 12;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_DSI  = 5'd2;
  localparam logic [4:0] EXC_ISI  = 5'd3;
  localparam logic [4:0] EXC_DTLB = 5'd13;
  localparam logic [4:0] EXC_ITLB = 5'd14;

  localparam int PERM_UX = 5;
  localparam int PERM_SX = 4;
  localparam int PERM_UW = 3;
  localparam int PERM_SW = 2;
  localparam int PERM_UR = 1;
  localparam int PERM_SR = 0;

  typedef enum logic [1:0] {
    ACC_NONE   = 2'd0,
    ACC_IFETCH = 2'd1,
    ACC_STORE  = 2'd2,
    ACC_LOAD   = 2'd3
  } acc_type_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_RESP   = 2'd2
  } search_state_e;

  // ifetch outranks store, which outranks load
  function automatic acc_type_e decode_acc(input logic ifetch, input logic store,
                                           input logic load);
    acc_type_e acc;
    if (ifetch) begin
      acc = ACC_IFETCH;
    end else if (store) begin
      acc = ACC_STORE;
    end else if (load) begin
      acc = ACC_LOAD;
    end else begin
      acc = ACC_NONE;
    end
    return acc;
  endfunction

endpackage

// File: rtl/tlb_entry_cmp.sv
// Combinational judge for one returned TLB entry: address/context match and
// permission check for the latched request.
module tlb_entry_cmp
  import ppc_mmu_pkg::*;
#(
  parameter int EPN_W = 20
) (
  input  logic [EPN_W-1:0] ea_epn,
  input  logic             req_as,
  input  logic             req_pr,
  input  acc_type_e        acc,
  input  logic [7:0]       pid0,
  input  logic [7:0]       pid1,
  input  logic [7:0]       pid2,
  input  logic             tlb_v,
  input  logic             tlb_ts,
  input  logic [7:0]       tlb_tid,
  input  logic [EPN_W-1:0] tlb_epn,
  input  logic [5:0]       tlb_permis,
  output logic             addr_match,
  output logic             perm_ok
);

  logic tid_ok_s;

  // TID 0 is a global mapping; otherwise any of the three PIDs may own it
  always_comb begin
    tid_ok_s   = (tlb_tid == 8'd0) || (tlb_tid == pid0) ||
                 (tlb_tid == pid1) || (tlb_tid == pid2);
    addr_match = tlb_v && (tlb_ts == req_as) && tid_ok_s && (tlb_epn == ea_epn);
    case (acc)
      ACC_IFETCH: perm_ok = req_pr ? tlb_permis[PERM_UX] : tlb_permis[PERM_SX];
      ACC_STORE:  perm_ok = req_pr ? tlb_permis[PERM_UW] : tlb_permis[PERM_SW];
      ACC_LOAD:   perm_ok = req_pr ? tlb_permis[PERM_UR] : tlb_permis[PERM_SR];
      default:    perm_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_search_ctrl.sv
// Sequential TLB search engine: walks all entries through a 1-cycle read port
// and returns the lowest-index match as a hit/PA or an exception code.
module tlb_search_ctrl
  import ppc_mmu_pkg::*;
#(
  parameter int NUM_ENTRIES = 16,
  parameter int IDX_W       = 4,
  parameter int EPN_W       = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_ea,
  input  logic             req_as,
  input  logic             req_pr,
  input  logic             req_ifetch,
  input  logic             req_store,
  input  logic             req_load,
  input  logic [7:0]       pid0,
  input  logic [7:0]       pid1,
  input  logic [7:0]       pid2,
  input  logic             abort,
  output logic             busy,
  output logic             tlb_rd_en,
  output logic [IDX_W-1:0] tlb_rd_idx,
  input  logic             tlb_v,
  input  logic             tlb_ts,
  input  logic [7:0]       tlb_tid,
  input  logic [EPN_W-1:0] tlb_epn,
  input  logic [EPN_W-1:0] tlb_rpn,
  input  logic [5:0]       tlb_permis,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_hit,
  output logic [IDX_W-1:0] rsp_idx,
  output logic [31:0]      rsp_pa,
  output logic [4:0]       rsp_exc
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  search_state_e    state_r, state_s;
  logic             ready_r, ready_s, busy_r, busy_s;
  logic             rd_en_r, rd_en_s;
  logic [IDX_W-1:0] rd_idx_r, rd_idx_s;
  logic             cmp_vld_r, cmp_vld_s;
  logic [IDX_W-1:0] cmp_idx_r, cmp_idx_s;
  logic [31:0]      ea_r, ea_s;
  logic             as_r, as_s, pr_r, pr_s;
  logic [7:0]       pid0_r, pid0_s, pid1_r, pid1_s, pid2_r, pid2_s;
  acc_type_e        acc_r, acc_s;
  logic             rsp_valid_r, rsp_valid_s, rsp_hit_r, rsp_hit_s;
  logic [IDX_W-1:0] rsp_idx_r, rsp_idx_s;
  logic [31:0]      rsp_pa_r, rsp_pa_s;
  logic [4:0]       rsp_exc_r, rsp_exc_s;
  logic             addr_match_s, perm_ok_s;

  tlb_entry_cmp #(.EPN_W(EPN_W)) u_cmp (
    .ea_epn     (ea_r[31 -: EPN_W]),
    .req_as     (as_r),
    .req_pr     (pr_r),
    .acc        (acc_r),
    .pid0       (pid0_r),
    .pid1       (pid1_r),
    .pid2       (pid2_r),
    .tlb_v      (tlb_v),
    .tlb_ts     (tlb_ts),
    .tlb_tid    (tlb_tid),
    .tlb_epn    (tlb_epn),
    .tlb_permis (tlb_permis),
    .addr_match (addr_match_s),
    .perm_ok    (perm_ok_s)
  );

  // Next-state and next-output computation for the whole engine
  always_comb begin
    state_s     = state_r;
    rd_en_s     = rd_en_r;
    rd_idx_s    = rd_idx_r;
    cmp_vld_s   = 1'b0;
    cmp_idx_s   = cmp_idx_r;
    ea_s        = ea_r;
    as_s        = as_r;
    pr_s        = pr_r;
    pid0_s      = pid0_r;
    pid1_s      = pid1_r;
    pid2_s      = pid2_r;
    acc_s       = acc_r;
    rsp_valid_s = rsp_valid_r;
    rsp_hit_s   = rsp_hit_r;
    rsp_idx_s   = rsp_idx_r;
    rsp_pa_s    = rsp_pa_r;
    rsp_exc_s   = rsp_exc_r;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && ready_r) begin
          ea_s   = req_ea;
          as_s   = req_as;
          pr_s   = req_pr;
          pid0_s = pid0;
          pid1_s = pid1;
          pid2_s = pid2;
          acc_s  = decode_acc(req_ifetch, req_store, req_load);
          if (acc_s == ACC_NONE) begin
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
            rsp_hit_s   = 1'b0;
            rsp_idx_s   = '0;
            rsp_pa_s    = 32'd0;
            rsp_exc_s   = EXC_NONE;
          end else begin
            state_s  = ST_SEARCH;
            rd_en_s  = 1'b1;
            rd_idx_s = '0;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SEARCH: begin
        if (abort) begin
          state_s  = ST_IDLE;
          rd_en_s  = 1'b0;
          rd_idx_s = '0;
        end else if (cmp_vld_r && addr_match_s) begin
          // first match ends the walk; the read already in flight is ignored
          state_s     = ST_RESP;
          rd_en_s     = 1'b0;
          rd_idx_s    = '0;
          rsp_valid_s = 1'b1;
          rsp_idx_s   = cmp_idx_r;
          if (perm_ok_s) begin
            rsp_hit_s = 1'b1;
            rsp_pa_s  = {tlb_rpn, ea_r[PAGE_SHIFT-1:0]};
            rsp_exc_s = EXC_NONE;
          end else begin
            rsp_hit_s = 1'b0;
            rsp_pa_s  = 32'd0;
            rsp_exc_s = (acc_r == ACC_IFETCH) ? EXC_ISI : EXC_DSI;
          end
        end else if (cmp_vld_r && (cmp_idx_r == LAST_IDX)) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
          rsp_hit_s   = 1'b0;
          rsp_idx_s   = '0;
          rsp_pa_s    = 32'd0;
          rsp_exc_s   = (acc_r == ACC_IFETCH) ? EXC_ITLB : EXC_DTLB;
        end else begin
          cmp_vld_s = rd_en_r;
          cmp_idx_s = rd_idx_r;
          if (rd_en_r && (rd_idx_r == LAST_IDX)) begin
            rd_en_s  = 1'b0;
            rd_idx_s = '0;
          end else if (rd_en_r) begin
            rd_idx_s = rd_idx_r + IDX_W'(1);
          end else begin
            rd_idx_s = rd_idx_r;
          end
        end
      end
      ST_RESP: begin
        if (abort || rsp_ready) begin
          state_s     = ST_IDLE;
          rsp_valid_s = 1'b0;
          rsp_hit_s   = 1'b0;
          rsp_idx_s   = '0;
          rsp_pa_s    = 32'd0;
          rsp_exc_s   = EXC_NONE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s     = ST_IDLE;
        rd_en_s     = 1'b0;
        rd_idx_s    = '0;
        rsp_valid_s = 1'b0;
        rsp_hit_s   = 1'b0;
        rsp_idx_s   = '0;
        rsp_pa_s    = 32'd0;
        rsp_exc_s   = EXC_NONE;
      end
    endcase
    ready_s = (state_s == ST_IDLE);
    busy_s  = (state_s == ST_SEARCH);
  end

  // State, request latches and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
      rd_en_r     <= 1'b0;
      rd_idx_r    <= '0;
      cmp_vld_r   <= 1'b0;
      cmp_idx_r   <= '0;
      ea_r        <= 32'd0;
      as_r        <= 1'b0;
      pr_r        <= 1'b0;
      pid0_r      <= 8'd0;
      pid1_r      <= 8'd0;
      pid2_r      <= 8'd0;
      acc_r       <= ACC_NONE;
      rsp_valid_r <= 1'b0;
      rsp_hit_r   <= 1'b0;
      rsp_idx_r   <= '0;
      rsp_pa_r    <= 32'd0;
      rsp_exc_r   <= EXC_NONE;
    end else begin
      state_r     <= state_s;
      ready_r     <= ready_s;
      busy_r      <= busy_s;
      rd_en_r     <= rd_en_s;
      rd_idx_r    <= rd_idx_s;
      cmp_vld_r   <= cmp_vld_s;
      cmp_idx_r   <= cmp_idx_s;
      ea_r        <= ea_s;
      as_r        <= as_s;
      pr_r        <= pr_s;
      pid0_r      <= pid0_s;
      pid1_r      <= pid1_s;
      pid2_r      <= pid2_s;
      acc_r       <= acc_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_hit_r   <= rsp_hit_s;
      rsp_idx_r   <= rsp_idx_s;
      rsp_pa_r    <= rsp_pa_s;
      rsp_exc_r   <= rsp_exc_s;
    end
  end

  assign req_ready  = ready_r;
  assign busy       = busy_r;
  assign tlb_rd_en  = rd_en_r;
  assign tlb_rd_idx = rd_idx_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_hit    = rsp_hit_r;
  assign rsp_idx    = rsp_idx_r;
  assign rsp_pa     = rsp_pa_r;
  assign rsp_exc    = rsp_exc_r;

endmodule
